// File: rtl/fifo_rd_burst.sv
// fifo_rd_burst: drains a FIFO read port into valid/ready bursts of up to BURST words, with o_last on the final word
module fifo_rd_burst #(
  parameter int DW      = 64,
  parameter int CW      = 10,
  parameter int BURST   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_rd,
  input  logic          rst_rd_n,
  input  logic          i_fifo_empty,
  input  logic [CW-1:0] i_fifo_words,
  input  logic [DW-1:0] i_fifo_data,
  output logic          o_fifo_rd_en,
  input  logic          i_flush,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_last,
  input  logic          i_ready,
  output logic          o_busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CW-1:0] BURST_W = CW'(BURST);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  logic [1:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [CW-1:0] pop_cnt_q, pop_cnt_d;
  logic          rd_q, rd_d, rd_last_q, rd_last_d;
  logic [1:0]    occ_q, occ_d, occ_p;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic          lst0_q, lst0_d, lst1_q, lst1_d;
  logic          deq, rd_en, trig_full, trig_part;
  always_comb begin
    deq = (occ_q != 2'd0) && i_ready;
    // reads in flight plus held words must stay within the two skid entries
    rd_en = rst_rd_n && state_q == S_BURST && pop_cnt_q != '0 && !i_fifo_empty &&
            (3'(occ_q) + 3'(rd_q) < 3'd2 + 3'(deq));
    trig_full = i_fifo_words >= BURST_W;
    trig_part = i_fifo_words != '0 && (timer_q >= TIMEOUT_W || i_flush);
    state_d = state_q;
    timer_d = 16'd0;
    pop_cnt_d = pop_cnt_q - CW'(rd_en);
    if (state_q == S_IDLE) begin
      timer_d = i_fifo_empty ? 16'd0 : (timer_q == 16'hffff ? timer_q : timer_q + 16'd1);
      if (trig_full || trig_part) begin
        state_d = S_BURST;
        timer_d = 16'd0;
        pop_cnt_d = trig_full ? BURST_W : i_fifo_words;
      end
    end else if (state_q == S_BURST) begin
      state_d = pop_cnt_d == '0 ? S_DRAIN : S_BURST;
    end else begin
      state_d = (deq && lst0_q) ? S_IDLE : state_q;
    end
    rd_d = rd_en;
    rd_last_d = rd_en && pop_cnt_q == CW'(1);
    occ_p = occ_q - 2'(deq);
    buf0_d = deq ? buf1_q : buf0_q;
    lst0_d = deq ? lst1_q : lst0_q;
    buf1_d = buf1_q;
    lst1_d = lst1_q;
    if (rd_q && occ_p == 2'd0) begin
      buf0_d = i_fifo_data;
      lst0_d = rd_last_q;
    end else if (rd_q) begin
      buf1_d = i_fifo_data;
      lst1_d = rd_last_q;
    end
    occ_d = occ_p + 2'(rd_q);
  end
  always_ff @(posedge clk_rd) begin
    if (!rst_rd_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pop_cnt_q <= '0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
      occ_q     <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      lst0_q    <= 1'b0;
      lst1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pop_cnt_q <= pop_cnt_d;
      rd_q      <= rd_d;
      rd_last_q <= rd_last_d;
      occ_q     <= occ_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      lst0_q    <= lst0_d;
      lst1_q    <= lst1_d;
    end
  end
  assign o_fifo_rd_en = rd_en;
  assign o_data  = buf0_q;
  assign o_valid = occ_q != 2'd0;
  assign o_last  = o_valid && lst0_q;
  assign o_busy  = state_q != S_IDLE;
endmodule

// File: tb/tb_fifo_rd_burst.sv
// tb_fifo_rd_burst: directed bench with a behavioural FIFO read port and handshake logger
module tb_fifo_rd_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty;
  logic [9:0]  words;
  logic [63:0] fdata = '0;
  logic        rd_en;
  logic        flush = 1'b0;
  logic [63:0] o_data;
  logic        o_valid, o_last;
  logic        ready = 1'b1;
  logic        busy;
  logic [63:0] mem [0:1023];
  int          wp = 0, rp = 0, cyc = 0;
  int          vectors = 0, errs = 0;
  int          stab_bad = 0, under_bad = 0;
  logic [63:0] log_d[$];
  bit          log_l[$];
  int          log_c[$];
  int          rd_cyc[$];
  logic        stall_p = 1'b0, pl = 1'b0;
  logic [63:0] pd = '0;

  fifo_rd_burst dut (
    .clk_rd(clk), .rst_rd_n(rst_n), .i_fifo_empty(empty), .i_fifo_words(words),
    .i_fifo_data(fdata), .o_fifo_rd_en(rd_en), .i_flush(flush), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .i_ready(ready), .o_busy(busy)
  );

  always #5 clk = ~clk;
  assign empty = wp == rp;
  assign words = 10'(wp - rp);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      fdata <= mem[rp[9:0]];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (o_valid && ready) begin
      log_d.push_back(o_data);
      log_l.push_back(o_last);
      log_c.push_back(cyc);
    end
    if (rd_en) rd_cyc.push_back(cyc);
    if (rd_en && empty) under_bad++;
    if (stall_p && (!o_valid || o_data !== pd || o_last !== pl)) stab_bad++;
    stall_p = o_valid && !ready;
    pd = o_data;
    pl = o_last;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp[9:0]] = base + 64'(i);
      wp++;
    end
  endtask

  task automatic wait_log(input int n, input int budget, input bit rnd);
    for (int i = 0; i < budget && log_d.size() < n; i++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      step(1);
    end
    ready = 1'b1;
    chk("log_count", 64'(log_d.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step(1);
    chk("idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int k, b, r, n, h;
    logic [63:0] exp_h;
    // reset held with a populated FIFO
    step(1);
    push(64'hDEAD_0000_0000_0000, 20);
    step(3);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_no_pop", 64'(rd_cyc.size()), 64'd0);
    wp = rp;
    rst_n = 1'b1;
    step(2);
    // full burst of 8 with ready held high
    b = log_d.size(); r = rd_cyc.size(); k = cyc;
    push(64'hD000_0000_0000_0000, 8);
    wait_log(b + 8, 100, 1'b0);
    chk("b8_rd_first", 64'(rd_cyc[r]), 64'(k + 1));
    chk("b8_rd_8th", 64'(rd_cyc[r + 7]), 64'(k + 8));
    chk("b8_first_valid", 64'(log_c[b]), 64'(k + 3));
    chk("b8_last_cycle", 64'(log_c[b + 7]), 64'(k + 10));
    chk("b8_d0", log_d[b], 64'hD000_0000_0000_0000);
    chk("b8_d7", log_d[b + 7], 64'hD000_0000_0000_0007);
    chk("b8_last6", 64'(log_l[b + 6]), 64'd0);
    chk("b8_last7", 64'(log_l[b + 7]), 64'd1);
    wait_idle(20);
    chk("b8_pops", 64'(rd_cyc.size() - r), 64'd8);
    // partial burst on idle timeout
    b = log_d.size(); r = rd_cyc.size(); k = cyc;
    push(64'hE000_0000_0000_0000, 3);
    wait_log(b + 3, 400, 1'b0);
    chk("to_rd_first", 64'(rd_cyc[r]), 64'(k + 256));
    chk("to_d2", log_d[b + 2], 64'hE000_0000_0000_0002);
    chk("to_last1", 64'(log_l[b + 1]), 64'd0);
    chk("to_last2", 64'(log_l[b + 2]), 64'd1);
    wait_idle(20);
    // 20 words, random backpressure: bursts of 8, 8, then 4 on timeout
    b = log_d.size();
    push(64'hA000_0000_0000_0000, 20);
    wait_log(b + 20, 3000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("rnd_order", log_d[b + i], 64'hA000_0000_0000_0000 + 64'(i));
      chk("rnd_last", 64'(log_l[b + i]), 64'(i == 7 || i == 15 || i == 19));
    end
    wait_idle(20);
    chk("rnd_stable", 64'(stab_bad), 64'd0);
    chk("rnd_underrun", 64'(under_bad), 64'd0);
    // flush in IDLE starts a burst of 5; flush during BURST ignored
    b = log_d.size(); r = rd_cyc.size(); k = cyc;
    push(64'hC000_0000_0000_0000, 5);
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(1);
    push(64'hC100_0000_0000_0000, 2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_log(b + 5, 100, 1'b0);
    wait_idle(20);
    chk("fl_rd_first", 64'(rd_cyc[r]), 64'(k + 3));
    chk("fl_pops", 64'(rd_cyc.size() - r), 64'd5);
    chk("fl_d4", log_d[b + 4], 64'hC000_0000_0000_0004);
    chk("fl_last4", 64'(log_l[b + 4]), 64'd1);
    b = log_d.size();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_log(b + 2, 100, 1'b0);
    chk("fl2_d0", log_d[b], 64'hC100_0000_0000_0000);
    chk("fl2_last", 64'(log_l[b + 1]), 64'd1);
    wait_idle(20);
    // reset after three words of an 8-word burst
    b = log_d.size();
    push(64'hF000_0000_0000_0000, 8);
    for (int i = 0; i < 100 && log_d.size() < b + 3; i++) step(1);
    rst_n = 1'b0;
    step(1);
    chk("mr_valid", 64'(o_valid), 64'd0);
    chk("mr_last", 64'(o_last), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_rd_en", 64'(rd_en), 64'd0);
    rst_n = 1'b1;
    n = wp - rp;
    h = rp;
    exp_h = mem[h[9:0]];
    chk("mr_remaining", 64'(n), 64'd3);
    step(1);
    b = log_d.size();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_log(b + n, 100, 1'b0);
    chk("mr_head", log_d[b], exp_h);
    chk("mr_head_val", log_d[b], 64'hF000_0000_0000_0005);
    chk("mr_tail_last", 64'(log_l[b + n - 1]), 64'd1);
    wait_idle(20);
    chk("end_stable", 64'(stab_bad), 64'd0);
    chk("end_underrun", 64'(under_bad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
